reconfig_write: RTL and testbench

Write-direction companion to the BPI reconfiguration read path. Accepts 256-byte configuration records as a byte stream on the control side, buffers one complete record, then packs it into 128 bit-reversed 16-bit words and delivers them to the BPI flash controller through a valid/ready handshake. It maintains a record counter and a status byte so software can confirm each record was committed.

---
 rtl/reconfig_write.sv | 129 ++++++++++++
 tb/tb_reconfig_write.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reconfig_write.sv
// Write-direction companion to the BPI reconfiguration read path: buffers one
// 256-byte record as 128 bit-reversed words and streams it to the BPI controller.
module reconfig_write #(
  parameter int unsigned FILL_TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  con_din,
  input  logic        con_din_en,
  input  logic        bpi_idle,
  input  logic        bpi_wr_rdy,
  output logic        bpi_wr_start,
  output logic [15:0] bpi_wr_data,
  output logic        bpi_wr_en,
  output logic        bpi_wr_end,
  output logic        busy,
  output logic [7:0]  write_status,
  output logic [15:0] write_count
);

  typedef enum logic [1:0] {IDLE, FILL, WAIT_BPI, SEND} state_t;

  localparam logic [9:0] GAP_LIMIT = 10'(FILL_TIMEOUT - 1);
  localparam logic [7:0] ST_OK     = 8'hAA;
  localparam logic [7:0] ST_BAD    = 8'h55;

  state_t      state;
  logic [8:0]  byte_idx;
  logic [6:0]  word_idx;
  logic [9:0]  gap_cnt;
  logic [7:0]  even_q;

  logic [15:0] mem [128];
  logic        mem_we;
  logic [6:0]  mem_waddr;
  logic [15:0] mem_wdata;

  function automatic logic [7:0] bitrev(input logic [7:0] b);
    return {<<{b}};
  endfunction

  // Odd bytes complete a word together with the held even byte.
  always_comb begin
    mem_we    = con_din_en && (state == FILL) && byte_idx[0];
    mem_waddr = byte_idx[7:1];
    mem_wdata = {bitrev(even_q), bitrev(con_din)};
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      byte_idx     <= '0;
      word_idx     <= '0;
      gap_cnt      <= '0;
      even_q       <= '0;
      bpi_wr_start <= 1'b0;
      bpi_wr_data  <= '0;
      bpi_wr_en    <= 1'b0;
      bpi_wr_end   <= 1'b0;
      busy         <= 1'b0;
      write_status <= '0;
      write_count  <= '0;
    end else begin
      bpi_wr_start <= 1'b0;
      bpi_wr_end   <= 1'b0;
      case (state)
        IDLE: begin
          if (con_din_en) begin
            even_q   <= con_din;
            byte_idx <= 9'd1;
            gap_cnt  <= '0;
            state    <= FILL;
          end
        end
        FILL: begin
          if (con_din_en) begin
            gap_cnt  <= '0;
            byte_idx <= byte_idx + 9'd1;
            if (!byte_idx[0]) even_q <= con_din;
            if (byte_idx == 9'd255) begin
              state <= WAIT_BPI;
              busy  <= 1'b1;
            end
          end else if (gap_cnt == GAP_LIMIT) begin
            state        <= IDLE;
            byte_idx     <= '0;
            gap_cnt      <= '0;
            write_status <= ST_BAD;
          end else begin
            gap_cnt <= gap_cnt + 10'd1;
          end
        end
        WAIT_BPI: begin
          if (con_din_en) write_status <= ST_BAD;
          if (bpi_idle) begin
            bpi_wr_start <= 1'b1;
            word_idx     <= '0;
            state        <= SEND;
          end
        end
        SEND: begin
          if (con_din_en) write_status <= ST_BAD;
          // en low is the RAM read slot; completion status overrides a same-cycle drop
          if (!bpi_wr_en) begin
            bpi_wr_data <= mem[word_idx];
            bpi_wr_en   <= 1'b1;
          end else if (bpi_wr_rdy) begin
            bpi_wr_en <= 1'b0;
            word_idx  <= word_idx + 7'd1;
            if (word_idx == 7'd127) begin
              bpi_wr_end   <= 1'b1;
              write_count  <= write_count + 16'd1;
              write_status <= ST_OK;
              busy         <= 1'b0;
              byte_idx     <= '0;
              state        <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reconfig_write.sv
// Bench for reconfig_write: vector table, corner-case sequences and random records
// checked against a byte-array reference model of the packed word stream.
module tb_reconfig_write;

  logic        clk;
  logic        rst;
  logic [7:0]  con_din;
  logic        con_din_en;
  logic        bpi_idle;
  logic        bpi_wr_rdy;
  logic        bpi_wr_start;
  logic [15:0] bpi_wr_data;
  logic        bpi_wr_en;
  logic        bpi_wr_end;
  logic        busy;
  logic [7:0]  write_status;
  logic [15:0] write_count;

  reconfig_write #(.FILL_TIMEOUT(1023)) dut (
    .clk(clk), .rst(rst), .con_din(con_din), .con_din_en(con_din_en),
    .bpi_idle(bpi_idle), .bpi_wr_rdy(bpi_wr_rdy), .bpi_wr_start(bpi_wr_start),
    .bpi_wr_data(bpi_wr_data), .bpi_wr_en(bpi_wr_en), .bpi_wr_end(bpi_wr_end),
    .busy(busy), .write_status(write_status), .write_count(write_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int start_cnt = 0;
  int end_cnt = 0;
  int en_cnt = 0;
  int start_cyc = 0;
  int end_cyc = 0;
  logic [15:0] got[$];
  logic [7:0]  rec[256];
  logic [15:0] exp_count = 16'd0;

  int rdy_mode = 0;
  int rdy_hi = 1;
  int rdy_lo = 0;
  int phase = 0;

  logic m_pend = 1'b0;
  logic m_acc = 1'b0;
  logic m_st = 1'b0;
  logic [15:0] m_data = 16'd0;

  typedef struct {
    int kind;
    logic [7:0] val;
    int mode;
    int hi;
    int lo;
    logic [15:0] w0;
    logic [15:0] w1;
    logic [15:0] w127;
  } vec_t;
  vec_t vecs[5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] b);
    int r = 0;
    for (int i = 0; i < 8; i++) if (b[i]) r += 1 << (7 - i);
    return 8'(r);
  endfunction

  function automatic logic [15:0] model_word(input int k);
    return {rev8(rec[2*k]), rev8(rec[2*k+1])};
  endfunction

  // Ready driver
  initial begin
    bpi_wr_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      phase++;
      case (rdy_mode)
        0: bpi_wr_rdy = 1'b1;
        1: bpi_wr_rdy = ((phase % (rdy_hi + rdy_lo)) < rdy_hi);
        default: bpi_wr_rdy = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Output monitor: handshake protocol checks and word capture
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        m_pend = 1'b0;
        m_acc = 1'b0;
        m_st = 1'b0;
      end else begin
        if (m_pend) begin
          total++;
          if (!(bpi_wr_en && bpi_wr_data == m_data)) begin
            bad++;
            $display("FAIL hold: en=%0b data=%h required en=1 data=%h", bpi_wr_en, bpi_wr_data, m_data);
          end
        end
        if (m_acc) begin
          total++;
          if (bpi_wr_en) begin
            bad++;
            $display("FAIL en_gap: en=1 required 0 after accept");
          end
        end
        if (m_st) begin
          total++;
          if (!bpi_wr_en) begin
            bad++;
            $display("FAIL start_to_en: en=0 required 1 cycle after start");
          end
        end
        if (bpi_wr_start) begin start_cnt++; start_cyc = cyc; end
        if (bpi_wr_end) begin end_cnt++; end_cyc = cyc; end
        if (bpi_wr_en) en_cnt++;
        if (bpi_wr_en && bpi_wr_rdy) got.push_back(bpi_wr_data);
        m_pend = bpi_wr_en && !bpi_wr_rdy;
        m_acc = bpi_wr_en && bpi_wr_rdy;
        m_st = bpi_wr_start;
        m_data = bpi_wr_data;
      end
    end
  end

  task automatic fill_record(input int max_gap);
    for (int i = 0; i < 256; i++) begin
      con_din = rec[i];
      con_din_en = 1'b1;
      tick();
      con_din_en = 1'b0;
      if (max_gap > 0) repeat ($urandom_range(0, max_gap)) tick();
    end
    con_din_en = 1'b0;
  endtask

  task automatic wait_end(input int old);
    int n = 0;
    while (end_cnt == old && n < 5000) begin
      tick();
      n++;
    end
    check("end_seen", 32'(end_cnt != old), 32'd1);
  endtask

  task automatic post_record(input int sc, input int ec);
    wait_end(ec);
    exp_count = exp_count + 16'd1;
    check("word_cnt", got.size(), 128);
    for (int k = 0; k < 128; k++)
      if (k < got.size()) check($sformatf("word%0d", k), got[k], model_word(k));
    check("count", write_count, exp_count);
    check("status_ok", write_status, 8'hAA);
    check("start_once", start_cnt - sc, 1);
    check("end_once", end_cnt - ec, 1);
    check("busy_done", busy, 0);
  endtask

  task automatic run_record(input int max_gap, input int idle_delay);
    int sc = start_cnt;
    int ec = end_cnt;
    got.delete();
    if (idle_delay > 0) bpi_idle = 1'b0;
    fill_record(max_gap);
    if (idle_delay > 0) begin
      repeat (idle_delay) tick();
      bpi_idle = 1'b1;
    end
    post_record(sc, ec);
  endtask

  task automatic random_rec();
    for (int i = 0; i < 256; i++) rec[i] = 8'($urandom);
  endtask

  initial begin
    int sc, ec, e0, n;

    vecs[0] = '{0, 8'h00, 0, 1, 0, 16'h0080, 16'h40C0, 16'h7FFF};
    vecs[1] = '{0, 8'h00, 1, 1, 3, 16'h0080, 16'h40C0, 16'h7FFF};
    vecs[2] = '{1, 8'hFF, 0, 1, 0, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    vecs[3] = '{1, 8'h01, 2, 1, 1, 16'h8080, 16'h8080, 16'h8080};
    vecs[4] = '{1, 8'h12, 1, 2, 1, 16'h4848, 16'h4848, 16'h4848};

    con_din = 8'h00;
    con_din_en = 1'b0;
    bpi_idle = 1'b1;
    rst = 1'b0;
    repeat (3) tick();
    check("rst_start", bpi_wr_start, 0);
    check("rst_en", bpi_wr_en, 0);
    check("rst_end", bpi_wr_end, 0);
    check("rst_busy", busy, 0);
    check("rst_data", bpi_wr_data, 0);
    check("rst_status", write_status, 8'h00);
    check("rst_count", write_count, 0);
    rst = 1'b1;
    tick();

    // Vector table
    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < 256; i++) rec[i] = (vecs[v].kind == 0) ? 8'(i) : vecs[v].val;
      rdy_mode = vecs[v].mode;
      rdy_hi = vecs[v].hi;
      rdy_lo = vecs[v].lo;
      run_record(0, 0);
      check($sformatf("vec%0d_w0", v), got.size() > 0 ? got[0] : 16'hxxxx, vecs[v].w0);
      check($sformatf("vec%0d_w1", v), got.size() > 1 ? got[1] : 16'hxxxx, vecs[v].w1);
      check($sformatf("vec%0d_w127", v), got.size() > 127 ? got[127] : 16'hxxxx, vecs[v].w127);
      if (vecs[v].mode == 0) check($sformatf("vec%0d_span", v), end_cyc - start_cyc, 256);
    end

    // bpi_idle held low after fill
    rdy_mode = 0;
    random_rec();
    got.delete();
    sc = start_cnt;
    ec = end_cnt;
    e0 = en_cnt;
    bpi_idle = 1'b0;
    fill_record(0);
    repeat (500) tick();
    check("idle_no_start", start_cnt - sc, 0);
    check("idle_no_en", en_cnt - e0, 0);
    check("idle_busy", busy, 1);
    bpi_idle = 1'b1;
    check("idle_start_not_yet", bpi_wr_start, 0);
    tick();
    check("idle_start", bpi_wr_start, 1);
    post_record(sc, ec);

    // Fill timeout
    sc = start_cnt;
    e0 = en_cnt;
    for (int i = 0; i < 100; i++) begin
      con_din = 8'($urandom);
      con_din_en = 1'b1;
      tick();
    end
    con_din_en = 1'b0;
    repeat (1000) tick();
    check("to_early", write_status, 8'hAA);
    repeat (30) tick();
    check("to_status", write_status, 8'h55);
    check("to_busy", busy, 0);
    check("to_no_start", start_cnt - sc, 0);
    check("to_no_en", en_cnt - e0, 0);
    random_rec();
    run_record(0, 0);
    check("to_first_byte", got.size() > 0 ? {8'h00, got[0][15:8]} : 16'hxxxx, {8'h00, rev8(rec[0])});

    // Bytes dropped during SEND
    rdy_mode = 1;
    rdy_hi = 1;
    rdy_lo = 3;
    random_rec();
    got.delete();
    sc = start_cnt;
    ec = end_cnt;
    fill_record(0);
    n = 0;
    while (got.size() == 0 && n < 2000) begin tick(); n++; end
    check("drop_send_seen", 32'(got.size() > 0), 32'd1);
    for (int i = 0; i < 10; i++) begin
      con_din = 8'($urandom);
      con_din_en = 1'b1;
      tick();
    end
    con_din_en = 1'b0;
    check("drop_status", write_status, 8'h55);
    check("drop_busy", busy, 1);
    post_record(sc, ec);
    rdy_mode = 2;
    random_rec();
    run_record(3, 5);

    // Random records
    for (int r = 0; r < 4; r++) begin
      rdy_mode = $urandom_range(0, 2);
      rdy_hi = $urandom_range(1, 2);
      rdy_lo = $urandom_range(0, 3);
      random_rec();
      run_record($urandom_range(0, 3), $urandom_range(0, 20));
    end

    // Async reset mid-burst
    rdy_mode = 0;
    random_rec();
    got.delete();
    ec = end_cnt;
    fill_record(0);
    n = 0;
    while (got.size() < 60 && n < 2000) begin tick(); n++; end
    check("rst_reach60", 32'(got.size() >= 60), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("arst_en", bpi_wr_en, 0);
    check("arst_start", bpi_wr_start, 0);
    check("arst_end", bpi_wr_end, 0);
    check("arst_busy", busy, 0);
    check("arst_data", bpi_wr_data, 0);
    check("arst_status", write_status, 8'h00);
    check("arst_count", write_count, 0);
    exp_count = 16'd0;
    repeat (3) tick();
    rst = 1'b1;
    repeat (300) tick();
    check("arst_no_end", end_cnt - ec, 0);
    check("arst_count_after", write_count, 0);
    check("arst_busy_after", busy, 0);
    random_rec();
    run_record(1, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
